// File: rtl/dadda_mac_if.sv
// Operand/result handshake bundle for the dadda multiply-accumulate stage.
// master drives operands and result ready; slave is the accumulator block.
interface dadda_mac_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, busy, out_valid, acc_out, overflow
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, busy, out_valid, acc_out, overflow
  );
endinterface

// File: rtl/dadda_mac_acc.sv
// Burst multiply-accumulate around an 8x8 Dadda-tree multiplier.
// Operand pairs are registered, multiplied, and summed into a wide sticky-overflow accumulator.

module dadda_8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p_c
);
  localparam int unsigned COLS = 17;
  localparam int unsigned MAXH = 10;
  localparam int unsigned CW   = 5;
  localparam int unsigned HW   = 4;

  // Column-wise Dadda reduction 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  function automatic logic [15:0] dadda_reduce(input logic [7:0] x, input logic [7:0] y);
    logic [MAXH-1:0] cur [COLS];
    logic [MAXH-1:0] nxt [COLS];
    int              ch  [COLS];
    int              nh  [COLS];
    int              d;
    int              src;
    int              rem;
    logic [CW-1:0]   ci;
    logic [CW-1:0]   cn;
    logic            s0;
    logic            s1;
    logic            s2;
    logic [15:0]     ra;
    logic [15:0]     rb;

    for (int unsigned c = 0; c < COLS; c++) begin
      cur[CW'(c)] = '0;
      nxt[CW'(c)] = '0;
      ch[CW'(c)]  = 0;
      nh[CW'(c)]  = 0;
    end

    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        ci = CW'(i + j);
        cur[ci][HW'(ch[ci])] = x[3'(i)] & y[3'(j)];
        ch[ci] = ch[ci] + 1;
      end
    end

    for (int unsigned st = 0; st < 4; st++) begin
      d = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
      for (int unsigned c = 0; c < COLS; c++) begin
        nxt[CW'(c)] = '0;
        nh[CW'(c)]  = 0;
      end
      // Carries into column c are already placed before c is reduced.
      for (int unsigned c = 0; c < COLS - 1; c++) begin
        ci  = CW'(c);
        cn  = CW'(c + 1);
        src = 0;
        for (int unsigned k = 0; k < MAXH; k++) begin
          rem = ch[ci] - src;
          if ((rem + nh[ci] - d >= 2) && (rem >= 3)) begin
            s0 = cur[ci][HW'(src)];
            s1 = cur[ci][HW'(src + 1)];
            s2 = cur[ci][HW'(src + 2)];
            nxt[ci][HW'(nh[ci])] = s0 ^ s1 ^ s2;
            nh[ci] = nh[ci] + 1;
            nxt[cn][HW'(nh[cn])] = (s0 & s1) | (s0 & s2) | (s1 & s2);
            nh[cn] = nh[cn] + 1;
            src = src + 3;
          end else if ((rem + nh[ci] - d >= 1) && (rem >= 2)) begin
            s0 = cur[ci][HW'(src)];
            s1 = cur[ci][HW'(src + 1)];
            nxt[ci][HW'(nh[ci])] = s0 ^ s1;
            nh[ci] = nh[ci] + 1;
            nxt[cn][HW'(nh[cn])] = s0 & s1;
            nh[cn] = nh[cn] + 1;
            src = src + 2;
          end
        end
        for (int unsigned k = 0; k < MAXH; k++) begin
          if (src < ch[ci]) begin
            nxt[ci][HW'(nh[ci])] = cur[ci][HW'(src)];
            nh[ci] = nh[ci] + 1;
            src = src + 1;
          end
        end
      end
      cur = nxt;
      ch  = nh;
    end

    for (int unsigned c = 0; c < 16; c++) begin
      ra[4'(c)] = cur[CW'(c)][0];
      rb[4'(c)] = cur[CW'(c)][1];
    end
    return ra + rb;
  endfunction

  assign o_p_c = dadda_reduce(i_a, i_b);
endmodule

module dadda_mac_acc #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dadda_mac_if.slave  bus
);
  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic             r_v1;
  logic [PW-1:0]    r_p;
  logic             r_v2;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic             w_in_ready_nxt;
  logic             w_busy_nxt;
  logic             w_out_valid_nxt;
  logic             w_xfer;
  logic             w_last;
  logic             w_out_fire;
  logic             w_start_run;
  logic             w_start_zero;
  logic [PW-1:0]    w_p_c;
  logic [ACC_W:0]   w_sum;

  assign w_xfer       = bus.in_valid & r_in_ready;
  assign w_last       = w_xfer && ((r_cnt + CNT_W'(1)) == r_len);
  assign w_out_fire   = r_out_valid & bus.out_ready;
  assign w_start_run  = (r_state == S_IDLE) && bus.start && (bus.len != '0);
  assign w_start_zero = (r_state == S_IDLE) && bus.start && (bus.len == '0);
  assign w_sum        = (ACC_W + 1)'(r_acc) + (ACC_W + 1)'(r_p);

  // State register; handshake outputs are registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_zero)     w_state_nxt = S_DONE;
        else if (w_start_run) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_v1 && !r_v2) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_out_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Staying in RUN implies count < len, so in_ready follows the next state alone.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_busy_nxt      = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_in_ready_nxt  = (w_state_nxt == S_RUN);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_start_run) begin
      r_len <= bus.len;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_v1 <= 1'b0;
      r_p  <= '0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_xfer;
      if (w_xfer) begin
        r_a <= bus.a;
        r_b <= bus.b;
      end
      r_p  <= w_p_c;
      r_v2 <= r_v1;
    end
  end

  dadda_8 u_mul (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_p_c (w_p_c)
  );

  // Accumulator holds its value through DONE/IDLE and clears only when a burst begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_start_run || w_start_zero) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_v2) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= r_ovf | w_sum[ACC_W];
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.acc_out   = r_acc;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_dadda_mac_acc.sv
// Bench for dadda_mac_acc: a 24-bit and a 17-bit accumulator share one stimulus stream
// and are compared against a plain sum-of-products model.
module tb_dadda_mac_acc;
  localparam longint M24 = 64'd16777216;
  localparam longint M17 = 64'd131072;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  dadda_mac_if #(.ACC_W(24), .CNT_W(8)) m ();
  dadda_mac_if #(.ACC_W(17), .CNT_W(8)) m17 ();

  assign m17.start     = m.start;
  assign m17.len       = m.len;
  assign m17.in_valid  = m.in_valid;
  assign m17.a         = m.a;
  assign m17.b         = m.b;
  assign m17.out_ready = m.out_ready;

  dadda_mac_acc #(.ACC_W(24), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  dadda_mac_acc #(.ACC_W(17), .CNT_W(8)) u_dut17 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint ref_sum();
    longint s = 0;
    foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
    return s;
  endfunction

  // Drives one burst from qa/qb and returns at the first negedge with out_valid=1.
  task automatic run_burst(input int n, input int gap, input bit rnd, output int lat, output bit tmo);
    int idx = 0;
    int cyc = 0;
    int g   = 0;
    bit take;
    tmo = 1'b0;
    @(negedge clk);
    m.start = 1'b1;
    m.len   = 8'(n);
    @(negedge clk);
    m.start = 1'b0;
    while (idx < n && cyc < 4000) begin
      if (g > 0) begin
        m.in_valid = 1'b0;
        g--;
      end else begin
        m.in_valid = 1'b1;
        m.a = qa[idx];
        m.b = qb[idx];
      end
      take = m.in_valid && m.in_ready;
      @(negedge clk);
      cyc++;
      if (take) begin
        idx++;
        g = rnd ? int'($urandom_range(0, 2)) : gap;
      end
    end
    m.in_valid = 1'b0;
    if (idx < n) tmo = 1'b1;
    lat = 0;
    while (!m.out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!m.out_valid) tmo = 1'b1;
  endtask

  task automatic release_out();
    m.out_ready = 1'b1;
    @(negedge clk);
    m.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    bit tmo;
    longint s;
    checks += 5;
    if (m.in_ready !== 1'b0)  begin failures++; $display("FAIL por_in_ready got=%b exp=0", m.in_ready); end
    if (m.busy !== 1'b0)      begin failures++; $display("FAIL por_busy got=%b exp=0", m.busy); end
    if (m.out_valid !== 1'b0) begin failures++; $display("FAIL por_out_valid got=%b exp=0", m.out_valid); end
    if (m.acc_out !== 24'd0)  begin failures++; $display("FAIL por_acc got=%0d exp=0", m.acc_out); end
    if (m.overflow !== 1'b0)  begin failures++; $display("FAIL por_ovf got=%b exp=0", m.overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    // Partial burst, then reset while RUN with products already accumulated.
    @(negedge clk);
    m.start = 1'b1;
    m.len   = 8'd5;
    @(negedge clk);
    m.start = 1'b0;
    m.in_valid = 1'b1; m.a = 8'd200; m.b = 8'd200;
    @(negedge clk);
    m.a = 8'd100; m.b = 8'd7;
    @(negedge clk);
    m.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks += 1;
    if (m.acc_out !== 24'd40700) begin failures++; $display("FAIL pre_rst_acc got=%0d exp=40700", m.acc_out); end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (m.in_ready !== 1'b0)   begin failures++; $display("FAIL rst_in_ready got=%b exp=0", m.in_ready); end
    if (m.busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", m.busy); end
    if (m17.busy !== 1'b0)     begin failures++; $display("FAIL rst_busy17 got=%b exp=0", m17.busy); end
    if (m.out_valid !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got=%b exp=0", m.out_valid); end
    if (m.acc_out !== 24'd0)   begin failures++; $display("FAIL rst_acc got=%0d exp=0", m.acc_out); end
    @(negedge clk);
    rst_n = 1'b1;
    qa = '{8'd2}; qb = '{8'd3};
    run_burst(1, 0, 1'b0, lat, tmo);
    s = ref_sum();
    checks += 3;
    if (tmo !== 1'b0) begin failures++; $display("FAIL rst_burst_timeout got=%b exp=0", tmo); end
    if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL rst_burst_acc got=%0d exp=%0d", m.acc_out, s % M24); end
    if (m.overflow !== 1'b0) begin failures++; $display("FAIL rst_burst_ovf got=%b exp=0", m.overflow); end
    release_out();
  endtask

  task automatic test_basic();
    int lat;
    bit tmo;
    longint s;
    qa = '{8'd3, 8'd7, 8'd255, 8'd0};
    qb = '{8'd5, 8'd9, 8'd255, 8'd200};
    run_burst(4, 0, 1'b0, lat, tmo);
    s = ref_sum();
    checks += 5;
    if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", tmo); end
    if (lat != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL basic_acc got=%0d exp=%0d", m.acc_out, s % M24); end
    if (m.overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", m.overflow); end
    if (m.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", m.busy); end
    release_out();
    checks += 1;
    if (m.busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", m.busy); end
  endtask

  task automatic test_zero_len();
    int lat;
    bit tmo;
    qa.delete(); qb.delete();
    run_burst(0, 0, 1'b0, lat, tmo);
    checks += 5;
    if (tmo !== 1'b0) begin failures++; $display("FAIL zero_timeout got=%b exp=0", tmo); end
    if (lat != 0) begin failures++; $display("FAIL zero_latency got=%0d exp=0", lat); end
    if (m.acc_out !== 24'd0) begin failures++; $display("FAIL zero_acc got=%0d exp=0", m.acc_out); end
    if (m.overflow !== 1'b0) begin failures++; $display("FAIL zero_ovf got=%b exp=0", m.overflow); end
    if (m.in_ready !== 1'b0) begin failures++; $display("FAIL zero_in_ready got=%b exp=0", m.in_ready); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    bit tmo;
    longint s;
    qa = '{8'd10, 8'd10, 8'd10};
    qb = '{8'd10, 8'd10, 8'd10};
    run_burst(3, 2, 1'b0, lat, tmo);
    s = ref_sum();
    checks += 2;
    if (tmo !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b exp=0", tmo); end
    if (lat != 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
    m.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m.start = 1'b1;
      m.len   = 8'(7 + i);
      @(negedge clk);
      checks += 4;
      if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL bp_hold_acc cyc=%0d got=%0d exp=%0d", i, m.acc_out, s % M24); end
      if (m.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, m.out_valid); end
      if (m.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, m.in_ready); end
      if (m.overflow !== 1'b0) begin failures++; $display("FAIL bp_hold_ovf cyc=%0d got=%b exp=0", i, m.overflow); end
    end
    m.start    = 1'b0;
    m.in_valid = 1'b0;
    release_out();
    checks += 2;
    if (m.busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", m.busy); end
    if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL bp_idle_acc got=%0d exp=%0d", m.acc_out, s % M24); end
  endtask

  task automatic test_overflow();
    int lat;
    bit tmo;
    longint s;
    qa = '{8'd255, 8'd255, 8'd255};
    qb = '{8'd255, 8'd255, 8'd255};
    run_burst(3, 0, 1'b0, lat, tmo);
    s = ref_sum();
    checks += 5;
    if (tmo !== 1'b0) begin failures++; $display("FAIL ovf_timeout got=%b exp=0", tmo); end
    if (m17.acc_out !== 17'(s % M17)) begin failures++; $display("FAIL ovf_acc17 got=%0d exp=%0d", m17.acc_out, s % M17); end
    if (m17.overflow !== 1'(s >= M17)) begin failures++; $display("FAIL ovf_flag17 got=%b exp=%b", m17.overflow, s >= M17); end
    if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL ovf_acc24 got=%0d exp=%0d", m.acc_out, s % M24); end
    if (m.overflow !== 1'(s >= M24)) begin failures++; $display("FAIL ovf_flag24 got=%b exp=%b", m.overflow, s >= M24); end
    release_out();
  endtask

  task automatic test_max_burst();
    int lat;
    bit tmo;
    longint s;
    qa.delete(); qb.delete();
    for (int i = 0; i < 255; i++) begin
      qa.push_back(8'd255);
      qb.push_back(8'd255);
    end
    run_burst(255, 0, 1'b0, lat, tmo);
    s = ref_sum();
    checks += 6;
    if (tmo !== 1'b0) begin failures++; $display("FAIL max_timeout got=%b exp=0", tmo); end
    if (lat != 3) begin failures++; $display("FAIL max_latency got=%0d exp=3", lat); end
    if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL max_acc24 got=%0d exp=%0d", m.acc_out, s % M24); end
    if (m.overflow !== 1'(s >= M24)) begin failures++; $display("FAIL max_ovf24 got=%b exp=%b", m.overflow, s >= M24); end
    if (m17.acc_out !== 17'(s % M17)) begin failures++; $display("FAIL max_acc17 got=%0d exp=%0d", m17.acc_out, s % M17); end
    if (m17.overflow !== 1'(s >= M17)) begin failures++; $display("FAIL max_ovf17 got=%b exp=%b", m17.overflow, s >= M17); end
    release_out();
    qa = '{8'd1}; qb = '{8'd1};
    run_burst(1, 0, 1'b0, lat, tmo);
    s = ref_sum();
    checks += 4;
    if (tmo !== 1'b0) begin failures++; $display("FAIL after_max_timeout got=%b exp=0", tmo); end
    if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL after_max_acc got=%0d exp=%0d", m.acc_out, s % M24); end
    if (m.overflow !== 1'b0) begin failures++; $display("FAIL after_max_ovf24 got=%b exp=0", m.overflow); end
    if (m17.overflow !== 1'b0) begin failures++; $display("FAIL after_max_ovf17 got=%b exp=0", m17.overflow); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit tmo;
    longint s;
    int n;
    m.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = int'($urandom_range(1, 12));
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(8'($urandom));
        qb.push_back(8'($urandom));
      end
      run_burst(n, 0, 1'b0, lat, tmo);
      s = ref_sum();
      checks += 3;
      if (tmo !== 1'b0) begin failures++; $display("FAIL b2b_timeout k=%0d got=%b exp=0", k, tmo); end
      if (lat != 3) begin failures++; $display("FAIL b2b_latency k=%0d got=%0d exp=3", k, lat); end
      if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL b2b_acc k=%0d got=%0d exp=%0d", k, m.acc_out, s % M24); end
      @(negedge clk);
      checks += 2;
      if (m.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_one_cycle k=%0d got=%b exp=0", k, m.out_valid); end
      if (m.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle k=%0d got=%b exp=0", k, m.busy); end
    end
    m.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    bit tmo;
    longint s;
    int n;
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 40));
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom));
        qb.push_back(($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom));
      end
      run_burst(n, 0, 1'b1, lat, tmo);
      s = ref_sum();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks += 6;
      if (tmo !== 1'b0) begin failures++; $display("FAIL rnd_timeout k=%0d got=%b exp=0", k, tmo); end
      if (lat != 3) begin failures++; $display("FAIL rnd_latency k=%0d got=%0d exp=3", k, lat); end
      if (m.acc_out !== 24'(s % M24)) begin failures++; $display("FAIL rnd_acc24 k=%0d got=%0d exp=%0d", k, m.acc_out, s % M24); end
      if (m.overflow !== 1'(s >= M24)) begin failures++; $display("FAIL rnd_ovf24 k=%0d got=%b exp=%b", k, m.overflow, s >= M24); end
      if (m17.acc_out !== 17'(s % M17)) begin failures++; $display("FAIL rnd_acc17 k=%0d got=%0d exp=%0d", k, m17.acc_out, s % M17); end
      if (m17.overflow !== 1'(s >= M17)) begin failures++; $display("FAIL rnd_ovf17 k=%0d got=%b exp=%b", k, m17.overflow, s >= M17); end
      release_out();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    m.start     = 1'b0;
    m.len       = 8'd0;
    m.in_valid  = 1'b0;
    m.a         = 8'd0;
    m.b         = 8'd0;
    m.out_ready = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_overflow();
    test_max_burst();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
